tracer_frame_scheduler: RTL and testbench
=========================================

Name: tracer_frame_scheduler

Overview:
Sequences the ray tracer over the 128x64 block grid, one block at a time, in raster order. For each block it issues a start/done handshake to the tracer and writes the returned 12-bit colour into the back buffer of the double RAM. At end of frame it waits for a VGA vsync pulse, then swaps front/back buffer select so the display never shows a partially rendered frame. It sits between ray_tracer_host's tracer core and double_ram and replaces the free-running enable toggling.

Parameters:
COLS, 128, blocks per row; COL_W = 7
ROWS, 64, block rows per frame; ROW_W = 6
PIX_W, 12, pixel width {b[3:0], g[3:0], r[3:0]}
TIMEOUT, 4096, tracer watchdog limit in clk cycles; used only with TRACER_TIMEOUT_EN

Ports:
clk  in  1  tracer-domain clock
rst  in  1  synchronous, active-high reset
enable  in  1  level; 1 = render frames continuously
vsync_pulse  in  1  one-cycle pulse at start of VGA vertical blank, already synchronised to clk
tracer_start  out  1  one-cycle request to the tracer
tracer_col  out  COL_W  block column for the current request
tracer_row  out  ROW_W  block row for the current request
tracer_done  in  1  one-cycle completion from the tracer
tracer_pixel  in  PIX_W  result colour, valid only with tracer_done
wr_en  out  1  one-cycle back-buffer write strobe
wr_col  out  COL_W  write column
wr_row  out  ROW_W  write row
wr_data  out  PIX_W  write data
buf_sel  out  1  front buffer read by VGA; writes always target ~buf_sel
frame_done  out  1  one-cycle pulse on buffer swap
frame_count  out  16  completed frames, wraps at 0xFFFF to 0
busy  out  1  1 in any state other than IDLE
timeout_err  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset values: all outputs 0, state IDLE, col = 0, row = 0, buf_sel = 0, frame_count = 0. Reset mid-frame abandons the frame with no write, no swap and no further tracer_start. A late tracer_done after reset is ignored.
- The FSM is registered and all outputs come from registers.
- IDLE: when enable = 1, clear col/row and go to ISSUE next cycle.
- ISSUE: tracer_start = 1 for exactly one cycle, with tracer_col/tracer_row = col/row held stable until the matching done. Then go to WAIT.
- WAIT: hold. When tracer_done = 1, latch tracer_pixel and go to WRITE. tracer_done in any other state is ignored.
- WRITE: wr_en = 1 for one cycle with wr_col/wr_row/wr_data.
  - If col == COLS-1 and row == ROWS-1, go to SWAP_WAIT.
  - Otherwise advance col (wraps 127 -> 0 and increments row) and go to ISSUE.
- SWAP_WAIT: hold until vsync_pulse. In that cycle: toggle buf_sel, pulse frame_done, increment frame_count. Next state is ISSUE at (0,0) if enable = 1, else IDLE.
- vsync_pulse outside SWAP_WAIT is ignored; no swap ever occurs mid-frame. A vsync in the same cycle as the last WRITE is ignored, and the swap waits for the next vsync.
- Deasserting enable mid-frame does not abort: the frame completes, swaps, then the block goes to IDLE.
- Per-block cost: ISSUE(1) + tracer latency L (>= 1) + WRITE(1) cycles. Minimum is 3 cycles per block with done in the cycle after start.
- The first wr_en of a frame occurs exactly 2 cycles after the cycle in which tracer_done is sampled high.

Optional Feature:
TRACER_TIMEOUT_EN
- Defined: a watchdog counter is cleared on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT with no tracer_done, the block writes ERR_COLOR 12'hF0F for the current block, sets timeout_err (sticky until rst), and continues normally through WRITE.
- Not defined: no counter is built, WAIT waits indefinitely, and timeout_err = 0.

Decomposition:
- Package tracer_pkg: COLS, ROWS, COL_W, ROW_W, PIX_W, pixel_t, ERR_COLOR, and the state enum {IDLE, ISSUE, WAIT, WRITE, SWAP_WAIT}.
- Sub-module raster_counter: col/row registers with clear and advance inputs and a last output. It is reused by the VGA address path.

Test Plan:
- Reset, enable = 1, tracer answers done 1 cycle after start with pixel = {row, col[5:0]} -> 8192 wr_en pulses in raster order; first write at (0,0), last at (127,63); no frame_done before vsync.
- vsync_pulse issued mid-frame and then after the last write -> buf_sel toggles 0 -> 1 only on the post-frame vsync; frame_done pulses once; frame_count = 1.
- Random tracer latency 1..20, spurious tracer_done while in ISSUE/WRITE -> no extra writes, and each wr_data equals the pixel returned for that coordinate.
- enable dropped at block 100 of frame 0 -> frame completes, swap on next vsync, then IDLE with busy = 0 and no further tracer_start.
- rst asserted during WAIT at (5,3) -> next cycle all outputs are 0 and buf_sel = 0; re-enable restarts at (0,0).
- With TRACER_TIMEOUT_EN and TIMEOUT = 16, the tracer never answers at (2,0) -> wr_data = 12'hF0F written at (2,0) 16 cycles after entering WAIT, timeout_err = 1, and the scheduler proceeds to (3,0).

Source files
------------

// File: rtl/tracer_pkg.sv
// tracer_pkg: shared constants and types for the frame scheduler and the
// raster counter.
//   COLS/ROWS   block grid dimensions (128 x 64)
//   COL_W/ROW_W coordinate widths
//   PIX_W       pixel width, {b[3:0], g[3:0], r[3:0]}
//   pixel_t     one pixel
//   ERR_COLOR   colour written for a block the tracer never answered
//   state_t     scheduler FSM states
package tracer_pkg;

  localparam int unsigned COLS  = 128;
  localparam int unsigned ROWS  = 64;
  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 6;
  localparam int unsigned PIX_W = 12;

  typedef logic [PIX_W-1:0] pixel_t;

  localparam pixel_t ERR_COLOR = 12'hF0F;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    SWAP_WAIT
  } state_t;

endpackage

// File: rtl/tracer_frame_scheduler_raster_counter.sv
// raster_counter: column/row position walking the block grid in raster order.
// Shared with the VGA address path.
//   clk      clock
//   rst      synchronous active-high reset, position -> (0,0)
//   clear    synchronous clear, position -> (0,0)
//   advance  step one block; column wraps to 0 and bumps the row, the last
//            block of the grid wraps back to (0,0)
//   col/row  current position (registered)
//   last     high while the position is the final block of the grid
module raster_counter
  import tracer_pkg::*;
#(
  parameter int unsigned NCOLS = COLS,
  parameter int unsigned NROWS = ROWS,
  parameter int unsigned CW    = COL_W,
  parameter int unsigned RW    = ROW_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic col_last;
  logic row_last;

  assign col_last = (col == CW'(NCOLS - 1));
  assign row_last = (row == RW'(NROWS - 1));
  assign last     = col_last && row_last;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tracer_frame_scheduler.sv
// tracer_frame_scheduler: walks the 128x64 block grid in raster order, issues
// one start/done handshake per block to the tracer, writes each returned pixel
// into the back buffer, and swaps front/back on the first vsync after the
// frame is complete so the display never shows a partial frame.
//
// Optional feature macro: TRACER_TIMEOUT_EN
//   When defined, a watchdog bounds each WAIT to TIMEOUT cycles; an
//   unanswered block is written as ERR_COLOR and timeout_err is set (sticky).
//   When undefined, WAIT waits indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   enable                level, 1 = render frames continuously
//   vsync_pulse           one-cycle pulse at start of vertical blank
//   tracer_start          one-cycle request, with tracer_col/tracer_row
//   tracer_done/pixel     one-cycle completion and its colour
//   wr_en/col/row/data    one-cycle back-buffer write
//   buf_sel               front buffer read by VGA; writes target ~buf_sel
//   frame_done            one-cycle pulse on buffer swap
//   frame_count           completed frames (wraps)
//   busy                  1 in any state other than IDLE
//   timeout_err           sticky watchdog flag
module tracer_frame_scheduler
  import tracer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             vsync_pulse,
  output logic             tracer_start,
  output logic [COL_W-1:0] tracer_col,
  output logic [ROW_W-1:0] tracer_row,
  input  logic             tracer_done,
  input  logic [PIX_W-1:0] tracer_pixel,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic [PIX_W-1:0] wr_data,
  output logic             buf_sel,
  output logic             frame_done,
  output logic [15:0]      frame_count,
  output logic             busy,
  output logic             timeout_err
);

  state_t             state;
  pixel_t             pix_q;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last;
  logic               ctr_clear;
  logic               ctr_advance;

  // The counter position is the block currently being traced; it only moves
  // at the end of WRITE, so it doubles as the stable request coordinate.
  assign ctr_clear   = (state == IDLE) && enable;
  assign ctr_advance = (state == WRITE);
  assign tracer_col  = col;
  assign tracer_row  = row;

  raster_counter #(
    .NCOLS (COLS),
    .NROWS (ROWS),
    .CW    (COL_W),
    .RW    (ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .advance (ctr_advance),
    .col     (col),
    .row     (row),
    .last    (last)
  );

`ifdef TRACER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
  logic            timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // tracer_start is raised on the transition into ISSUE so it is high during
  // the ISSUE cycle itself; wr_en is raised on the way out of WRITE, landing
  // two cycles after the cycle that sampled tracer_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pix_q        <= '0;
      tracer_start <= 1'b0;
      wr_en        <= 1'b0;
      wr_col       <= '0;
      wr_row       <= '0;
      wr_data      <= '0;
      buf_sel      <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      busy         <= 1'b0;
`ifdef TRACER_TIMEOUT_EN
      wd            <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      tracer_start <= 1'b0;
      wr_en        <= 1'b0;
      frame_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state        <= ISSUE;
            tracer_start <= 1'b1;
            busy         <= 1'b1;
          end
        end

        ISSUE: begin
          state <= WAIT;
`ifdef TRACER_TIMEOUT_EN
          wd    <= '0;
`endif
        end

        WAIT: begin
          if (tracer_done) begin
            pix_q <= tracer_pixel;
            state <= WRITE;
          end
`ifdef TRACER_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT - 1)) begin
            pix_q         <= ERR_COLOR;
            timeout_err_q <= 1'b1;
            state         <= WRITE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end

        WRITE: begin
          wr_en   <= 1'b1;
          wr_col  <= col;
          wr_row  <= row;
          wr_data <= pix_q;
          if (last) begin
            state <= SWAP_WAIT;
          end else begin
            state        <= ISSUE;
            tracer_start <= 1'b1;
          end
        end

        SWAP_WAIT: begin
          if (vsync_pulse) begin
            buf_sel     <= ~buf_sel;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            if (enable) begin
              state        <= ISSUE;
              tracer_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tracer_frame_scheduler.sv
module tb_tracer_frame_scheduler;
  import tracer_pkg::*;

  localparam int unsigned TO     = 16;
  localparam int          NBLK   = COLS * ROWS;
  localparam int          CYCMAX = 90000;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             vsync_pulse;
  logic             tracer_start;
  logic [COL_W-1:0] tracer_col;
  logic [ROW_W-1:0] tracer_row;
  logic             tracer_done;
  logic [PIX_W-1:0] tracer_pixel;
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  logic [PIX_W-1:0] wr_data;
  logic             buf_sel;
  logic             frame_done;
  logic [15:0]      frame_count;
  logic             busy;
  logic             timeout_err;

  tracer_frame_scheduler #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .vsync_pulse  (vsync_pulse),
    .tracer_start (tracer_start),
    .tracer_col   (tracer_col),
    .tracer_row   (tracer_row),
    .tracer_done  (tracer_done),
    .tracer_pixel (tracer_pixel),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .buf_sel      (buf_sel),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Expected back-buffer write: coordinate, colour, and the cycle it must
  // appear on (0 = timing not checked).
  typedef struct {
    int col;
    int row;
    int data;
    int due;
  } wr_t;

  wr_t exp_q[$];

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int issue_idx = 0;
  int writes    = 0;
  int starts    = 0;
  int fd_cnt    = 0;
  int mute_idx  = -1;
  int cnt       = 0;
  int pcol      = 0;
  int prow      = 0;
  int pix       = 0;
  int last_col  = -1;
  int last_row  = -1;
  int s0        = 0;
  int w0        = 0;
  bit pend      = 1'b0;
  bit muted     = 1'b0;
  bit vs_next   = 1'b0;
  bit lastvs_en = 1'b0;
  bit mid_vs    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, "_tracer_start"}, 32'(tracer_start), 0);
    check({ph, "_tracer_col"},   32'(tracer_col),   0);
    check({ph, "_tracer_row"},   32'(tracer_row),   0);
    check({ph, "_wr_en"},        32'(wr_en),        0);
    check({ph, "_wr_col"},       32'(wr_col),       0);
    check({ph, "_wr_row"},       32'(wr_row),       0);
    check({ph, "_wr_data"},      32'(wr_data),      0);
    check({ph, "_buf_sel"},      32'(buf_sel),      0);
    check({ph, "_frame_done"},   32'(frame_done),   0);
    check({ph, "_frame_count"},  32'(frame_count),  0);
    check({ph, "_busy"},         32'(busy),         0);
    check({ph, "_timeout_err"},  32'(timeout_err),  0);
  endtask

  // One clock of the tracer model plus the write scoreboard. Observes at the
  // falling edge, then drives inputs for the next rising edge.
  task automatic cycle();
    wr_t e;
    wr_t n;
    @(negedge clk);
    cyc++;

    if (wr_en) begin
      writes++;
      last_col = int'(wr_col);
      last_row = int'(wr_row);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_col",  32'(wr_col),  e.col);
        check("wr_row",  32'(wr_row),  e.row);
        check("wr_data", 32'(wr_data), e.data);
        if (e.due != 0) check("wr_timing", cyc, e.due);
      end
    end
    if (frame_done) fd_cnt++;

    tracer_done = 1'b0;
    vsync_pulse = vs_next;
    vs_next     = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        tracer_done  = 1'b1;
        tracer_pixel = pix[PIX_W-1:0];
        n.col  = pcol;
        n.row  = prow;
        n.data = pix;
        n.due  = cyc + 2;
        exp_q.push_back(n);
        pend = 1'b0;
        if (lastvs_en && pcol == COLS - 1 && prow == ROWS - 1) vs_next = 1'b1;
      end
    end else if (!muted && $urandom_range(0, 5) == 0) begin
      tracer_done  = 1'b1;
      tracer_pixel = PIX_W'($urandom);
    end

    if (tracer_start) begin
      starts++;
      pcol = issue_idx % COLS;
      prow = (issue_idx / COLS) % ROWS;
      check("issue_col", 32'(tracer_col), pcol);
      check("issue_row", 32'(tracer_row), prow);
      if (issue_idx == mute_idx) begin
        muted = 1'b1;
`ifdef TRACER_TIMEOUT_EN
        n.col  = pcol;
        n.row  = prow;
        n.data = int'(ERR_COLOR);
        n.due  = 0;
        exp_q.push_back(n);
`endif
      end else begin
        pend = 1'b1;
        pix  = int'($urandom_range(0, 4095));
        cnt  = (issue_idx < 300) ? int'($urandom_range(1, 20)) : 1;
      end
      issue_idx = (issue_idx + 1) % NBLK;
    end
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    vsync_pulse  = 1'b0;
    tracer_done  = 1'b0;
    tracer_pixel = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) cycle();
    check("idle_busy",   32'(busy), 0);
    check("idle_starts", starts,    0);

    // Frame 0: random latency on early blocks, spurious dones, enable dropped
    // after block 100, a vsync mid-frame and one on the last WRITE cycle.
    enable    = 1'b1;
    lastvs_en = 1'b1;
    while (writes < NBLK && cyc < CYCMAX) begin
      if (writes >= 100) enable = 1'b0;
      if (writes == 4000 && !mid_vs) begin
        vs_next = 1'b1;
        mid_vs  = 1'b1;
      end
      if (writes == 4010) check("midframe_buf_sel", 32'(buf_sel), 0);
      cycle();
    end
    check("frame0_writes",  writes,   NBLK);
    check("frame0_last_col", last_col, COLS - 1);
    check("frame0_last_row", last_row, ROWS - 1);
    check("no_swap_yet_fd",  fd_cnt,   0);
    repeat (20) cycle();
    check("swap_wait_buf_sel", 32'(buf_sel),     0);
    check("swap_wait_fd",      fd_cnt,           0);
    check("swap_wait_busy",    32'(busy),        1);
    check("swap_wait_count",   32'(frame_count), 0);
    check("swap_wait_writes",  writes,           NBLK);

    vs_next = 1'b1;
    repeat (3) cycle();
    check("swap_fd",          fd_cnt,           1);
    check("swap_buf_sel",     32'(buf_sel),     1);
    check("swap_frame_count", 32'(frame_count), 1);
    check("swap_busy",        32'(busy),        0);
    s0 = starts;
    repeat (30) cycle();
    check("after_swap_starts", starts,     s0);
    check("after_swap_busy",   32'(busy),  0);
    check("after_swap_fd",     fd_cnt,     1);
    check("after_swap_writes", writes,     NBLK);

    // Reset while WAITing on block (5,3); the tracer never answers it.
    issue_idx = 0;
    writes    = 0;
    lastvs_en = 1'b0;
    mute_idx  = 3 * COLS + 5;
    enable    = 1'b1;
    while (!muted && cyc < CYCMAX) cycle();
    check("reached_block_5_3", 32'(muted), 1);
    repeat (3) cycle();
    check("wait_5_3_busy", 32'(busy), 1);
    rst    = 1'b1;
    enable = 1'b0;
    cycle();
    rst = 1'b0;
    check_all_zero("midreset");
    exp_q.delete();
    pend      = 1'b0;
    muted     = 1'b0;
    issue_idx = 0;
    mute_idx  = -1;
    tracer_done  = 1'b1;
    tracer_pixel = 12'h5A5;
    s0 = starts;
    w0 = writes;
    repeat (20) cycle();
    check("post_reset_starts", starts,            s0);
    check("post_reset_writes", writes,            w0);
    check("post_reset_busy",   32'(busy),         0);
    check("post_reset_count",  32'(frame_count),  0);

    // Re-enable: restart at (0,0). With the watchdog built, block (2,0) is
    // left unanswered and must be written as the error colour.
    writes = 0;
`ifdef TRACER_TIMEOUT_EN
    mute_idx = 2;
`endif
    enable = 1'b1;
    while (writes < 10 && cyc < CYCMAX) begin
      if (muted && issue_idx > 3) muted = 1'b0;
      cycle();
    end
    check("restart_writes", writes, 10);
`ifdef TRACER_TIMEOUT_EN
    check("timeout_err", 32'(timeout_err), 1);
`else
    check("timeout_err", 32'(timeout_err), 0);
`endif
    check("restart_buf_sel", 32'(buf_sel), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
